// File: rtl/bcd_stopwatch.sv
// BCD stopwatch / countdown timer: MM:SS.cc with preset, lap freeze and expiry.
// Feeds the 6-digit seven-segment driver directly.
module bcd_stopwatch #(
  parameter int CLK_FREQ = 50000000,
  parameter int TICK_HZ  = 100,
  parameter int PRE_W    = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        dir,
  input  logic        load,
  input  logic [23:0] load_val,
  input  logic        lap,
  output logic [23:0] out,
  output logic        running,
  output logic        tick,
  output logic        wrap,
  output logic        done
);

  localparam int DIV = CLK_FREQ / TICK_HZ;
  localparam logic [PRE_W-1:0] LAST = PRE_W'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    EXPIRED
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [PRE_W-1:0] pre;
  logic [23:0]      cnt;
  logic [23:0]      cnt_step;
  logic [23:0]      lap_q;
  logic             freeze;
  logic             carry;
  logic             tick_now;
  logic             zero;
  logic             hit_zero;

  // Digit order from LSB: c0 c1 s0 s1 m0 m1; tens of s/m top out at 5.
  function automatic logic [3:0] dmax(input int i);
    return (i == 3 || i == 5) ? 4'd5 : 4'd9;
  endfunction

  function automatic logic [24:0] bcd_step(
    input logic [23:0] v,
    input logic        down
  );
    logic [23:0] r;
    logic [3:0]  d;
    logic [3:0]  mx;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d  = v[4*i +: 4];
      mx = dmax(i);
      if (c) begin
        if (down) begin
          c = (d == 4'd0);
          r[4*i +: 4] = c ? mx : d - 4'd1;
        end else begin
          c = (d >= mx);
          r[4*i +: 4] = c ? 4'd0 : d + 4'd1;
        end
      end
    end
    return {c, r};
  endfunction

  function automatic logic [23:0] bcd_sat(input logic [23:0] v);
    logic [23:0] r;
    logic [3:0]  d;
    r = v;
    for (int i = 0; i < 6; i++) begin
      d = v[4*i +: 4];
      if (d > dmax(i)) r[4*i +: 4] = dmax(i);
    end
    return r;
  endfunction

  assign tick_now = (state == RUN) && (pre == LAST);
  assign zero     = (cnt == 24'd0);
  assign {carry, cnt_step} = bcd_step(cnt, dir);
  assign hit_zero = tick_now && dir && !zero && (cnt_step == 24'd0);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (start) state_n = RUN;
      end
      RUN: begin
        if (hit_zero && !load) state_n = EXPIRED;
        else if (!start)       state_n = IDLE;
      end
      EXPIRED: begin
        if (!start)             state_n = IDLE;
        else if (load || !dir)  state_n = RUN;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pre     <= '0;
      cnt     <= '0;
      lap_q   <= '0;
      freeze  <= 1'b0;
      out     <= '0;
      running <= 1'b0;
      tick    <= 1'b0;
      wrap    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      running <= (state_n == RUN);
      tick    <= tick_now && !load;
      wrap    <= tick_now && !load && !dir && carry;
      done    <= hit_zero && !load;
      out     <= freeze ? lap_q : cnt;
      if (load) begin
        cnt    <= bcd_sat(load_val);
        pre    <= '0;
        freeze <= 1'b0;
      end else begin
        // Lap captures the count as it was before this edge's tick.
        if (lap) begin
          freeze <= !freeze;
          if (!freeze) lap_q <= cnt;
        end
        if (tick_now) begin
          pre <= '0;
          if (!dir || !zero) cnt <= cnt_step;
        end else if (state == RUN) begin
          pre <= pre + PRE_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Directed bench for bcd_stopwatch with a cycle model feeding a scoreboard.
// Model counts in plain centiseconds and converts to BCD only at the edges.
module tb_bcd_stopwatch;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        dir;
  logic        load;
  logic [23:0] load_val;
  logic        lap;
  logic [23:0] out;
  logic        running;
  logic        tick;
  logic        wrap;
  logic        done;

  bcd_stopwatch #(
    .CLK_FREQ(1000),
    .TICK_HZ (100),
    .PRE_W   (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .dir     (dir),
    .load    (load),
    .load_val(load_val),
    .lap     (lap),
    .out     (out),
    .running (running),
    .tick    (tick),
    .wrap    (wrap),
    .done    (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] out;
    logic        run;
    logic        tk;
    logic        wr;
    logic        dn;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  int m_st  = 0;
  int m_pre = 0;
  int m_cnt = 0;
  int m_lap = 0;
  bit m_frz = 1'b0;

  function automatic logic [23:0] to_bcd(input int t);
    int mi;
    int se;
    int cs;
    mi = t / 6000;
    se = (t / 100) % 60;
    cs = t % 100;
    return {4'(mi / 10), 4'(mi % 10), 4'(se / 10),
            4'(se % 10), 4'(cs / 10), 4'(cs % 10)};
  endfunction

  function automatic int from_bcd(input logic [23:0] v);
    int d[6];
    int lim;
    for (int i = 0; i < 6; i++) begin
      d[i] = int'(v[4*i +: 4]);
      lim  = (i == 3 || i == 5) ? 5 : 9;
      if (d[i] > lim) d[i] = lim;
    end
    return (d[5] * 10 + d[4]) * 6000 + (d[3] * 10 + d[2]) * 100
           + d[1] * 10 + d[0];
  endfunction

  task automatic chk(input string tag, input logic [23:0] got,
                     input logic [23:0] want);
    n_cmp++;
    assert (got === want)
    else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic step();
    exp_t e;
    int   ncnt;
    int   npre;
    int   nst;
    int   nlap;
    bit   nfrz;
    bit   tk;
    bit   nt;
    bit   nw;
    bit   nd;
    e = '0;
    if (rst) begin
      m_st  = 0;
      m_pre = 0;
      m_cnt = 0;
      m_lap = 0;
      m_frz = 1'b0;
    end else begin
      tk   = (m_st == 1) && (m_pre == 9);
      ncnt = m_cnt;
      npre = m_pre;
      nst  = m_st;
      nfrz = m_frz;
      nlap = m_lap;
      nt   = 1'b0;
      nw   = 1'b0;
      nd   = 1'b0;
      e.out = to_bcd(m_frz ? m_lap : m_cnt);
      if (load) begin
        ncnt = from_bcd(load_val);
        npre = 0;
        nfrz = 1'b0;
      end else begin
        if (lap) begin
          nfrz = !m_frz;
          if (!m_frz) nlap = m_cnt;
        end
        if (tk) begin
          npre = 0;
          nt   = 1'b1;
          if (!dir) begin
            if (m_cnt == 359999) begin
              ncnt = 0;
              nw   = 1'b1;
            end else begin
              ncnt = m_cnt + 1;
            end
          end else if (m_cnt > 0) begin
            ncnt = m_cnt - 1;
            nd   = (ncnt == 0);
          end
        end else if (m_st == 1) begin
          npre = m_pre + 1;
        end
      end
      case (m_st)
        0: if (start) nst = 1;
        1: begin
          if (nd)          nst = 2;
          else if (!start) nst = 0;
        end
        default: begin
          if (!start)            nst = 0;
          else if (load || !dir) nst = 1;
        end
      endcase
      e.run = (nst == 1);
      e.tk  = nt;
      e.wr  = nw;
      e.dn  = nd;
      m_st  = nst;
      m_pre = npre;
      m_cnt = ncnt;
      m_lap = nlap;
      m_frz = nfrz;
    end
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk("out", out, e.out);
    chk("running", 24'(running), 24'(e.run));
    chk("tick", 24'(tick), 24'(e.tk));
    chk("wrap", 24'(wrap), 24'(e.wr));
    chk("done", 24'(done), 24'(e.dn));
  endtask

  initial begin
    int nd;
    rst      = 1'b1;
    start    = 1'b0;
    dir      = 1'b0;
    load     = 1'b0;
    load_val = '0;
    lap      = 1'b0;

    // reset and plain up-count
    repeat (3) step();
    chk("rst_out", out, 24'h000000);
    rst   = 1'b0;
    start = 1'b1;
    repeat (125) step();
    chk("run_out", out, 24'h000012);
    chk("run_running", 24'(running), 24'd1);

    // pause / resume keeps the partial prescaler period
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (45) step();
    chk("pre_pause", out, 24'h000004);
    start = 1'b0;
    repeat (50) step();
    chk("paused_out", out, 24'h000004);
    chk("paused_run", 24'(running), 24'd0);
    start = 1'b1;
    repeat (6) step();
    chk("resume_tick", 24'(tick), 24'd1);
    step();
    chk("resume_out", out, 24'h000005);

    // wrap at 59:59.99
    load_val = 24'h595998;
    load     = 1'b1;
    step();
    load = 1'b0;
    repeat (20) step();
    chk("wrap_pulse", 24'(wrap), 24'd1);
    chk("wrap_last", out, 24'h595999);
    step();
    chk("wrap_clear", 24'(wrap), 24'd0);
    chk("wrap_out", out, 24'h000000);

    // countdown to expiry
    dir      = 1'b1;
    load_val = 24'h000102;
    load     = 1'b1;
    step();
    load = 1'b0;
    nd   = 0;
    for (int i = 0; i < 1200 && nd == 0; i++) begin
      step();
      if (done) nd++;
    end
    chk("done_seen", 24'(nd), 24'd1);
    chk("expired_run", 24'(running), 24'd0);
    repeat (100) begin
      step();
      if (done) nd++;
    end
    chk("done_once", 24'(nd), 24'd1);
    chk("expired_out", out, 24'h000000);

    // lap freeze coincident with a tick, then release
    dir = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (80) step();
    lap = 1'b1;
    step();
    lap = 1'b0;
    chk("lap_tick", 24'(tick), 24'd1);
    chk("lap_cap", out, 24'h000007);
    repeat (73) step();
    chk("lap_frozen", out, 24'h000007);
    lap = 1'b1;
    step();
    lap = 1'b0;
    step();
    chk("lap_release", out, 24'h000015);

    // saturating load beats a same-edge tick, then mid-run reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (10) step();
    load_val = 24'hFA7C9B;
    load     = 1'b1;
    step();
    load = 1'b0;
    chk("ld_notick", 24'(tick), 24'd0);
    chk("ld_nowrap", 24'(wrap), 24'd0);
    step();
    chk("sat_out", out, 24'h595999);
    repeat (5) step();
    rst = 1'b1;
    step();
    chk("midrst_out", out, 24'h000000);
    chk("midrst_run", 24'(running), 24'd0);
    rst = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_stopwatch.md
Name: bcd_stopwatch

Overview:
Parametrised BCD stopwatch/countdown timer, the successor to the fixed stopwatch used in stage 1. It prescales the system clock to a configurable tick rate and counts MM:SS.cc in packed BCD, either up or down. It adds preset load, lap freeze of the display, and a countdown-expiry flag. It feeds the 6-digit seven-segment driver directly.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
TICK_HZ, 100, count rate in Hz; one LSB (centisecond) per tick; DIV = CLK_FREQ/TICK_HZ, DIV >= 2 required
PRE_W, 32, prescaler counter width; must hold DIV-1

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
start  in  1  level; 1 = run, 0 = pause (count and prescaler hold)
dir  in  1  0 = count up, 1 = count down
load  in  1  single-cycle pulse; load load_val into the count
load_val  in  24  preset {m1,m0,s1,s0,c1,c0}, 4-bit BCD each
lap  in  1  single-cycle pulse; toggles display freeze
out  out  24  displayed value, same packing as load_val
running  out  1  1 while in RUN state
tick  out  1  one-cycle pulse on each count update
wrap  out  1  one-cycle pulse when up-count rolls 59:59.99 -> 00:00.00
done  out  1  one-cycle pulse when down-count reaches 00:00.00

Behaviour:
- Clock is clk only. Reset is synchronous, active-high on rst. rst=1 at a clock edge sets the following: count=0, out=0, prescaler=0, freeze=0, state=IDLE, running/tick/wrap/done=0. Reset mid-count behaves the same.
- States:
  - IDLE: start=0. Go to RUN when start=1.
  - RUN: prescaler increments every cycle. Go to IDLE when start=0.
  - EXPIRED: count held at zero after a down-count completes. Go to RUN on load, or when dir=0 and start=1. Go to IDLE when start=0.
- Prescaler counts 0..DIV-1. On the cycle it equals DIV-1 in RUN, it returns to 0 and a tick occurs. The count updates on that same edge, and the tick pulse is high for that one cycle.
- Pausing holds the prescaler value. Resuming continues the partial period.
- Up count:
  - c0 0..9 carries into c1 0..9, which carries into s0 0..9, then s1 0..5, then m0 0..9, then m1 0..5.
  - 59:59.99 + tick gives 00:00.00, wrap=1 for one cycle, counting continues.
- Down count:
  - Mirror borrow chain: c0 0 -> 9 with borrow, s1 0 -> 5, m1 0 -> 5.
  - A tick that produces 00:00.00 asserts done for one cycle and enters EXPIRED. No further decrements.
  - A down tick when the count is already 0 never wraps.
- dir may change at any cycle. The new direction applies from the next tick and the prescaler is not reset.
- load:
  - Count takes load_val, prescaler clears to 0, freeze clears.
  - Any digit above its maximum (c/s0/m0 > 9, s1/m1 > 5) saturates to that maximum.
  - load_val = 0 with dir=1 does not assert done.
- Priority at one edge: rst > load > tick. A load coinciding with a tick discards the tick, and its tick/wrap/done pulses stay 0.
- Lap freeze:
  - A lap pulse with freeze=0 captures the pre-update count, i.e. the value before any same-edge tick. It then sets freeze=1, and out shows the captured value while the count keeps running.
  - A lap pulse with freeze=1 clears freeze, and out shows the live count from the next cycle.
- out is registered. When not frozen, out equals the count one cycle after it updates, so display latency is 1 cycle.
- running=1 exactly in RUN. start=1 during rst is ignored until the cycle after reset.

Test Plan (CLK_FREQ=1000, TICK_HZ=100, DIV=10):
1. Reset/run: rst high for 3 cycles, then start=1, dir=0 for 125 cycles -> out=0x000012, tick every 10th cycle, running=1.
2. Pause/resume: start=0 after 45 cycles (4 ticks), hold 50 cycles, start=1 for 6 cycles -> out stays 0x000004 during the pause, then 0x000005 on the 6th resumed cycle.
3. Wrap: load 0x595998, dir=0, run 20 cycles -> 0x595999, then 0x000000 with wrap=1 for one cycle, counting continues.
4. Countdown: load 0x000102, dir=1, run -> 0x000101, 0x000100, 0x000099 ... 0x000000. done pulses once, state EXPIRED, out holds 0 for 100 further cycles.
5. Lap: count to 0x000007, pulse lap coincident with a tick -> out frozen at 0x000007 while the count advances. Second lap at count 0x000015 -> out=0x000015 the next cycle.
6. Saturation/priority: load 0xFA7C9B coincident with a tick -> out=0x595999, no tick/wrap pulse. Assert rst mid-run -> all outputs 0 the next cycle.
